// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/acknowledge bus between cache controller and memory responder
//
// Purpose: groups the request (cs/wea/addra/dina) and response (douta/ack/busy)
// signals of the cache-to-memory port.
// Modports:
//   master - cache controller side: drives cs, wea, addra, dina; observes douta, ack, busy
//   slave  - memory responder side: observes the request, drives douta, ack, busy

interface mem_responder_if #(
    parameter int ADDR_W = 10
);
    logic              cs;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic [31:0]       douta;
    logic              ack;
    logic              busy;

    modport master (
        output cs, wea, addra, dina,
        input  douta, ack, busy
    );

    modport slave (
        input  cs, wea, addra, dina,
        output douta, ack, busy
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM responder with fixed programmable access latency
//
// Purpose: accepts one request at a time on the cache-to-memory bus, holds it for
// LATENCY cycles and completes it with a single-cycle ack pulse. Reads return
// data on douta in the ack cycle; writes commit on the edge that enters RESP.
// Ports:
//   clka  - clock, all state changes on the rising edge
//   rstn  - asynchronous active-low reset (storage array is not reset)
//   bus   - mem_responder_if.slave: cs/wea/addra/dina in, douta/ack/busy out
// Parameters:
//   ADDR_W  - word address width, depth = 2**ADDR_W words of 32 bits
//   LATENCY - cycles from acceptance to the end of the ack cycle, 1..15

module mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic           clka,
    input  logic           rstn,
    mem_responder_if.slave bus
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_wea;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_din;
    logic [3:0]        r_cnt;
    logic [31:0]       r_douta;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [31:0]       w_acc_din;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cs) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                // Never accept on the edge leaving RESP; cs is sampled again in IDLE.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: ack and busy follow the registered state directly
    // ------------------------------------------------------------------
    always_comb begin
        bus.ack   = (r_state == S_RESP);
        bus.busy  = (r_state != S_IDLE);
        bus.douta = r_douta;
    end

    // ------------------------------------------------------------------
    // Access control
    // ------------------------------------------------------------------
    assign w_accept     = (r_state == S_IDLE) && bus.cs;
    assign w_enter_resp = (w_next == S_RESP);

    // With LATENCY=1 the RESP-entry edge is the acceptance edge itself, so the
    // access must use the live bus inputs; otherwise it uses the latched request.
    assign w_acc_we   = (r_state == S_IDLE) ? bus.wea   : r_wea;
    assign w_acc_addr = (r_state == S_IDLE) ? bus.addra : r_addr;
    assign w_acc_din  = (r_state == S_IDLE) ? bus.dina  : r_din;

    // ------------------------------------------------------------------
    // Request latch and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_wea  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_wea  <= bus.wea;
                r_addr <= bus.addra;
                r_din  <= bus.dina;
                r_cnt  <= LAT_M1;
            end else if (r_state == S_WAIT) begin
                r_cnt  <= r_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data register: loaded only on RESP entry for reads, holds otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_douta <= '0;
        end else if (w_enter_resp && !w_acc_we) begin
            r_douta <= r_mem[w_acc_addr];
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset). The rstn term blocks a write on an edge that
    // arrives while reset is held, e.g. cs=1 in IDLE with LATENCY=1.
    // ------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (rstn && w_enter_resp && w_acc_we) begin
            r_mem[w_acc_addr] <= w_acc_din;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder at LATENCY=4 and LATENCY=1

module tb_mem_responder;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(10)) b4 ();
    mem_responder_if #(.ADDR_W(10)) b1 ();

    mem_responder #(.ADDR_W(10), .LATENCY(4)) u4 (
        .clka (clk),
        .rstn (rstn),
        .bus  (b4)
    );

    mem_responder #(.ADDR_W(10), .LATENCY(1)) u1 (
        .clka (clk),
        .rstn (rstn),
        .bus  (b1)
    );

    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] mdl4 [int];
    logic [31:0] mdl1 [int];
    int          wq4 [$];
    int          wq1 [$];
    logic [31:0] lastrd [2];

    function automatic int lat(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    task automatic drive(input int sel, input logic cs, input logic we,
                         input logic [9:0] a, input logic [31:0] d);
        if (sel == 0) begin
            b4.cs = cs; b4.wea = we; b4.addra = a; b4.dina = d;
        end else begin
            b1.cs = cs; b1.wea = we; b1.addra = a; b1.dina = d;
        end
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? b4.ack : b1.ack;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? b4.busy : b1.busy;
    endfunction

    function automatic logic [31:0] get_dout(input int sel);
        return (sel == 0) ? b4.douta : b1.douta;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_rd(input int sel, input int a);
        if (sel == 0) return mdl4.exists(a) ? mdl4[a] : 32'h0;
        return mdl1.exists(a) ? mdl1[a] : 32'h0;
    endfunction

    task automatic mdl_wr(input int sel, input int a, input logic [31:0] d);
        if (sel == 0) begin
            if (!mdl4.exists(a)) wq4.push_back(a);
            mdl4[a] = d;
        end else begin
            if (!mdl1.exists(a)) wq1.push_back(a);
            mdl1[a] = d;
        end
    endtask

    // One request from an idle responder. Expected behaviour: busy for exactly
    // L cycles after acceptance, ack only in the last of them, idle after.
    // mode 0: cs held until ack; 1: cs dropped after one cycle;
    // mode 2: random churn on all inputs while busy; 3: cs kept high through RESP.
    task automatic do_req(input int sel, input logic we, input logic [9:0] a,
                          input logic [31:0] d, input int mode);
        int          L;
        logic [31:0] exp_rd;
        L = lat(sel);
        drive(sel, 1'b1, we, a, d);
        for (int k = 0; k < L; k++) begin
            @(posedge clk); #1;
            chk("busy_held", 32'(get_busy(sel)), 32'd1);
            chk("ack_timing", 32'(get_ack(sel)), 32'(k == L - 1));
            if (k == L - 1) begin
                if (we) begin
                    mdl_wr(sel, int'(a), d);
                    chk("dout_hold_on_write", get_dout(sel), lastrd[sel]);
                end else begin
                    exp_rd = mdl_rd(sel, int'(a));
                    chk("read_data", get_dout(sel), exp_rd);
                    lastrd[sel] = exp_rd;
                end
                if (mode != 3) drive(sel, 1'b0, 1'b0, 10'h0, 32'h0);
            end else begin
                case (mode)
                    1: drive(sel, 1'b0, 1'($urandom), 10'($urandom), $urandom);
                    2: drive(sel, 1'($urandom), 1'($urandom), 10'($urandom), $urandom);
                    default: ;
                endcase
            end
        end
        @(posedge clk); #1;
        chk("idle_busy", 32'(get_busy(sel)), 32'd0);
        chk("idle_ack", 32'(get_ack(sel)), 32'd0);
        chk("dout_keep", get_dout(sel), lastrd[sel]);
    endtask

    initial begin
        int          sel;
        int          mode;
        int          nxt_sel;
        logic        we;
        logic [9:0]  a;

        lastrd[0] = 32'h0;
        lastrd[1] = 32'h0;
        drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 10'h0, 32'h0);

        // Reset state
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst_ack4", 32'(b4.ack), 32'd0);
        chk("rst_busy4", 32'(b4.busy), 32'd0);
        chk("rst_dout4", b4.douta, 32'h0);
        chk("rst_ack1", 32'(b1.ack), 32'd0);
        chk("rst_busy1", 32'(b1.busy), 32'd0);
        chk("rst_dout1", b1.douta, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Basic latency and readback at the top address
        do_req(0, 1'b1, 10'h3FF, 32'h12345678, 0);
        do_req(0, 1'b0, 10'h3FF, 32'h0, 0);

        // Write-back then fill, back to back with cs=~ack
        do_req(0, 1'b1, 10'h001, 32'h0000BEEF, 0);
        do_req(0, 1'b1, 10'h021, 32'hA5A5A5A5, 0);
        do_req(0, 1'b0, 10'h001, 32'h0, 0);
        do_req(0, 1'b0, 10'h021, 32'h0, 0);

        // LATENCY=1: ack the cycle after acceptance, back-to-back every two cycles
        do_req(1, 1'b1, 10'h005, 32'h55AA0005, 0);
        do_req(1, 1'b0, 10'h005, 32'h0, 0);
        do_req(1, 1'b0, 10'h005, 32'h0, 0);

        // Abandoned write still commits and acks
        do_req(0, 1'b1, 10'h100, 32'hCAFEF00D, 1);
        do_req(0, 1'b0, 10'h100, 32'h0, 0);

        // Input churn while busy
        do_req(0, 1'b1, 10'h0AB, 32'h13572468, 2);
        do_req(0, 1'b0, 10'h0AB, 32'h0, 2);

        // cs held through RESP is not accepted on the exit edge
        do_req(0, 1'b1, 10'h0C0, 32'h0BADF00D, 3);
        do_req(0, 1'b0, 10'h0C0, 32'h0, 0);

        // Reset during WAIT aborts the write and suppresses ack
        do_req(0, 1'b1, 10'h010, 32'h0, 0);
        drive(0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("abort_accepted", 32'(b4.busy), 32'd1);
        drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("abort_busy", 32'(b4.busy), 32'd0);
        chk("abort_ack", 32'(b4.ack), 32'd0);
        chk("abort_dout", b4.douta, 32'h0);
        lastrd[0] = 32'h0;
        lastrd[1] = 32'h0;
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_ack_after_abort", 32'(b4.ack), 32'd0);
        end
        do_req(0, 1'b0, 10'h010, 32'h0, 0);

        // Randomized traffic on both responders
        nxt_sel = -1;
        for (int it = 0; it < 60; it++) begin
            sel  = (nxt_sel >= 0) ? nxt_sel : int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 3));
            if (it == 59) mode = 0;
            nxt_sel = (mode == 3) ? sel : -1;
            if (sel == 0) begin
                we = (wq4.size() == 0) ? 1'b1 : 1'($urandom);
                a  = we ? 10'($urandom) : 10'(wq4[$urandom_range(0, wq4.size() - 1)]);
            end else begin
                we = (wq1.size() == 0) ? 1'b1 : 1'($urandom);
                a  = we ? 10'($urandom) : 10'(wq1[$urandom_range(0, wq1.size() - 1)]);
            end
            do_req(sel, we, a, $urandom, mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
